rs_dec: RTL and testbench

- Streaming single-error-correcting decoder for the team's 10-symbol RS codeword over GF(16). Each codeword holds 8 data symbols followed by 2 parity symbols.
- Sits at the receive end of the link, opposite the RS encoder.
- Computes the two syndromes while a frame arrives, then replays the buffered frame with at most one symbol corrected. It flags uncorrectable frames.
- A ping-pong buffer lets frame N+1 be received while frame N is replayed.

---
 rtl/rs_dec_if.sv | 24 ++
 rtl/rs_dec.sv | 204 ++++++++++++++++++++
 tb/tb_rs_dec.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_dec_if.sv
// Symbol-stream bus of the RS(10,8) decoder: received symbols in, corrected symbols
// and per-frame status out.
interface rs_dec_if #(
    parameter int SYM_W = 4
);
    logic             in_valid;
    logic             in_sof;
    logic [SYM_W-1:0] x;
    logic             out_valid;
    logic             out_sof;
    logic [SYM_W-1:0] y;
    logic             out_corr;
    logic             out_fail;

    modport master (
        output in_valid, in_sof, x,
        input  out_valid, out_sof, y, out_corr, out_fail
    );

    modport slave (
        input  in_valid, in_sof, x,
        output out_valid, out_sof, y, out_corr, out_fail
    );
endinterface

// File: rtl/rs_dec.sv
// Streaming single-error-correcting RS(10,8) decoder over GF(16): syndromes are built while a
// frame arrives into one bank of a ping-pong buffer, then the frame is replayed with the located symbol fixed.
module rs_dec #(
    parameter int SYM_W = 4,
    parameter int N_SYM = 10,
    parameter int K_SYM = 8
) (
    input  logic    clk,
    input  logic    reset,
    rs_dec_if.slave bus
);
    localparam int         NSYN = N_SYM - K_SYM;
    localparam logic [3:0] LAST = 4'(N_SYM - 1);

    typedef enum logic { IN_HUNT, IN_RECV } in_state_e;
    typedef enum logic { OUT_IDLE, OUT_PLAY } out_state_e;

    // Multiply by alpha in GF(2^4), p(x) = x^4 + x + 1.
    function automatic logic [SYM_W-1:0] mul_a(input logic [SYM_W-1:0] a);
        return {a[SYM_W-2:0], 1'b0} ^ (a[SYM_W-1] ? 4'b0011 : 4'b0000);
    endfunction

    // Constant power k only, so this unrolls into a fixed XOR network.
    function automatic logic [SYM_W-1:0] mul_pow(input logic [SYM_W-1:0] a, input int k);
        logic [SYM_W-1:0] r;
        r = a;
        for (int j = 0; j < 15; j++) begin
            if (j < k) r = mul_a(r);
        end
        return r;
    endfunction

    in_state_e                   in_state_q, in_state_d;
    logic [3:0]                  k_q, k_d;
    logic                        wbank_q, wbank_d;
    logic [NSYN-1:0][SYM_W-1:0]  syn_q, syn_d, syn_acc;
    logic                        wr_en;
    logic [3:0]                  wr_idx;
    logic                        done;

    out_state_e                  out_state_q, out_state_d;
    logic [3:0]                  pidx_q, pidx_d;
    logic                        pbank_q, pbank_d;
    logic [SYM_W-1:0]            v_q, v_d, t_q, t_d, s2_q, s2_d;
    logic                        s1nz_q, s1nz_d;
    logic                        matched_q, matched_d, matched_prev;
    logic                        playing, match, load;
    logic                        rd_bank;
    logic [3:0]                  rd_idx;
    logic [SYM_W-1:0]            rd_q;

    logic                        out_valid_q, out_valid_d;
    logic                        out_sof_q, out_sof_d;
    logic [SYM_W-1:0]            y_q, y_d;
    logic                        out_corr_q, out_corr_d;
    logic                        out_fail_q, out_fail_d;

    logic [SYM_W-1:0]            sym_mem [2][N_SYM];

    // Horner step for syndrome gi+1 (evaluated at alpha^(gi+1)); a start-of-frame symbol restarts from zero.
    generate
        for (genvar gi = 0; gi < NSYN; gi++) begin : g_syn
            assign syn_acc[gi] = (bus.in_sof ? '0 : mul_pow(syn_q[gi], gi + 1)) ^ bus.x;
        end
    endgenerate

    always_comb begin
        in_state_d = in_state_q;
        k_d        = k_q;
        wbank_d    = wbank_q;
        syn_d      = syn_q;
        wr_en      = 1'b0;
        wr_idx     = k_q;
        done       = 1'b0;
        if (bus.in_valid && bus.in_sof) begin
            wr_en      = 1'b1;
            wr_idx     = '0;
            k_d        = 4'd1;
            in_state_d = IN_RECV;
            syn_d      = syn_acc;
        end else if (bus.in_valid && (in_state_q == IN_RECV)) begin
            wr_en = 1'b1;
            syn_d = syn_acc;
            if (k_q == LAST) begin
                done       = 1'b1;
                k_d        = '0;
                in_state_d = IN_HUNT;
                wbank_d    = ~wbank_q;
            end else begin
                k_d = k_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state_q <= IN_HUNT;
            k_q        <= '0;
            wbank_q    <= 1'b0;
            syn_q      <= '0;
        end else begin
            in_state_q <= in_state_d;
            k_q        <= k_d;
            wbank_q    <= wbank_d;
            syn_q      <= syn_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) sym_mem[wbank_q][wr_idx] <= bus.x;
        rd_q <= sym_mem[rd_bank][rd_idx];
    end

    // V = S1*alpha^d is compared against S2; T = S1*alpha^-d is the error value at degree d.
    always_comb begin
        out_state_d = out_state_q;
        pidx_d      = pidx_q;
        pbank_d     = pbank_q;
        v_d         = v_q;
        t_d         = t_q;
        s2_d        = s2_q;
        s1nz_d      = s1nz_q;
        load        = 1'b0;
        rd_bank     = pbank_q;
        rd_idx      = (pidx_q == LAST) ? '0 : pidx_q + 4'd1;

        playing      = (out_state_q == OUT_PLAY);
        match        = playing && s1nz_q && (v_q == s2_q);
        matched_prev = (pidx_q != '0) && matched_q;
        matched_d    = playing && (matched_prev || match);
        out_valid_d  = playing;
        out_sof_d    = playing && (pidx_q == '0);
        y_d          = playing ? (rd_q ^ (match ? t_q : '0)) : '0;
        out_corr_d   = match;
        out_fail_d   = playing && (pidx_q == LAST) && (s1nz_q || (s2_q != '0))
                       && !(matched_prev || match);

        case (out_state_q)
            OUT_IDLE: load = done;
            OUT_PLAY: begin
                if (pidx_q == LAST) begin
                    load = done;
                    if (!done) out_state_d = OUT_IDLE;
                end else begin
                    pidx_d = pidx_q + 4'd1;
                    v_d    = mul_pow(v_q, 14);
                    t_d    = mul_pow(t_q, 1);
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase

        // A frame finishing on the last replay cycle reloads directly, giving back-to-back playback.
        if (load) begin
            out_state_d = OUT_PLAY;
            pidx_d      = '0;
            pbank_d     = wbank_q;
            rd_bank     = wbank_q;
            rd_idx      = '0;
            v_d         = mul_pow(syn_acc[0], N_SYM - 1);
            t_d         = mul_pow(syn_acc[0], 15 - ((N_SYM - 1) % 15));
            s2_d        = syn_acc[1];
            s1nz_d      = (syn_acc[0] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_state_q <= OUT_IDLE;
            pidx_q      <= '0;
            pbank_q     <= 1'b0;
            v_q         <= '0;
            t_q         <= '0;
            s2_q        <= '0;
            s1nz_q      <= 1'b0;
            matched_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            y_q         <= '0;
            out_corr_q  <= 1'b0;
            out_fail_q  <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            pidx_q      <= pidx_d;
            pbank_q     <= pbank_d;
            v_q         <= v_d;
            t_q         <= t_d;
            s2_q        <= s2_d;
            s1nz_q      <= s1nz_d;
            matched_q   <= matched_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            y_q         <= y_d;
            out_corr_q  <= out_corr_d;
            out_fail_q  <= out_fail_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.y         = y_q;
    assign bus.out_corr  = out_corr_q;
    assign bus.out_fail  = out_fail_q;
endmodule

// File: tb/tb_rs_dec.sv
// Randomized bench for rs_dec: frames are decoded by a log-table GF(16) reference model
// and the captured output stream is compared symbol by symbol.
module tb_rs_dec;
    typedef logic [3:0] frame_t [10];
    typedef struct {
        logic [3:0] y;
        logic       sof;
        logic       corr;
        logic       fail;
        int         cyc;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   idle_bad = 0;
    int   last_in_cyc = 0;
    obs_t cap_q[$];
    obs_t exp_q[$];
    int         gf_log [16];
    logic [3:0] gf_exp [15];

    rs_dec_if bus_if ();

    rs_dec dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_if.out_valid === 1'b1)
            cap_q.push_back('{y: bus_if.y, sof: bus_if.out_sof, corr: bus_if.out_corr,
                              fail: bus_if.out_fail, cyc: cyc});
        else if ({bus_if.y, bus_if.out_sof, bus_if.out_corr, bus_if.out_fail} !== 7'd0)
            idle_bad++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- GF(16) reference arithmetic ----------------
    task automatic build_tables();
        int e;
        e = 1;
        for (int i = 0; i < 15; i++) begin
            gf_exp[i] = 4'(e);
            gf_log[e] = i;
            e = e << 1;
            if ((e & 16) != 0) e = e ^ 19;
        end
    endtask

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'd0 || b == 4'd0) return 4'd0;
        return gf_exp[(gf_log[a] + gf_log[b]) % 15];
    endfunction

    function automatic logic [3:0] apow(input int k);
        return gf_exp[k % 15];
    endfunction

    // Expected decoder output for one received frame.
    task automatic model_push(input frame_t f);
        logic [3:0] s1, s2, e;
        int         pos, d;
        logic       bad;
        s1 = 4'd0; s2 = 4'd0; e = 4'd0; pos = -1; bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s1 ^= gmul(f[i], apow(9 - i));
            s2 ^= gmul(f[i], apow(2 * (9 - i)));
        end
        if (s1 != 4'd0 && s2 != 4'd0) begin
            d = (gf_log[s2] - gf_log[s1] + 15) % 15;
            if (d <= 9) begin
                pos = 9 - d;
                e   = gmul(s1, apow(15 - d));
            end else begin
                bad = 1'b1;
            end
        end else if (s1 != 4'd0 || s2 != 4'd0) begin
            bad = 1'b1;
        end
        for (int i = 0; i < 10; i++)
            exp_q.push_back('{y: f[i] ^ ((i == pos) ? e : 4'd0), sof: (i == 0), corr: (i == pos),
                              fail: (bad && (i == 9)), cyc: 0});
    endtask

    // Random data with parity solved from c(alpha) = c(alpha^2) = 0.
    task automatic make_codeword(output frame_t f);
        logic [3:0] d1, d2, p8;
        d1 = 4'd0; d2 = 4'd0;
        for (int i = 0; i < 8; i++) begin
            f[i] = 4'($urandom_range(0, 15));
            d1 ^= gmul(f[i], apow(9 - i));
            d2 ^= gmul(f[i], apow(2 * (9 - i)));
        end
        p8   = gmul(d1 ^ d2, apow(10));
        f[8] = p8;
        f[9] = d1 ^ gmul(p8, apow(1));
    endtask

    task automatic add_errors(inout frame_t f, input int n);
        for (int j = 0; j < n; j++)
            f[$urandom_range(0, 9)] ^= 4'($urandom_range(1, 15));
    endtask

    // ---------------- stimulus ----------------
    task automatic send_sym(input logic v, input logic s, input logic [3:0] d);
        @(negedge clk);
        bus_if.in_valid = v;
        bus_if.in_sof   = s;
        bus_if.x        = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_sym(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    endtask

    task automatic send_frame(input frame_t f, input int gap);
        for (int i = 0; i < 10; i++) begin
            send_sym(1'b1, (i == 0), f[i]);
            if (i == 9) last_in_cyc = cyc;
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic wait_caps(input int n);
        for (int w = 0; w < 800 && cap_q.size() < n; w++) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        frame_t f;
        reset = 1'b0;
        send_frame('{default: 4'd0}, 0);
        idle(12);
        n_checks++;
        if ({bus_if.out_valid, bus_if.out_sof, bus_if.out_corr, bus_if.out_fail} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags got %b want 0000",
                     {bus_if.out_valid, bus_if.out_sof, bus_if.out_corr, bus_if.out_fail});
        end
        n_checks++;
        if (bus_if.y !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_y got %h want 0", bus_if.y);
        end
        reset = 1'b1;
        idle(3);
        cap_q.delete();
        make_codeword(f);
        for (int i = 0; i < 10; i++) send_sym(1'b1, 1'b0, f[i]);
        idle(15);
        n_checks++;
        if (cap_q.size() != 0) begin
            n_errors++;
            $display("FAIL hunt_no_sof got %0d outputs want 0", cap_q.size());
        end
        $display("tb: reset and hunt checked");
    endtask

    task automatic test_directed();
        frame_t f;
        int     first_last;
        cap_q.delete(); exp_q.delete();
        f = '{default: 4'd0};
        send_frame(f, 0); model_push(f);
        first_last = last_in_cyc;
        idle(2);
        send_frame(f, 0); model_push(f);
        idle(3);
        f[7] = 4'd1; f[8] = 4'd6; f[9] = 4'd8;
        send_frame(f, 0); model_push(f);
        idle(3);
        f = '{default: 4'd0}; f[3] = 4'd5;
        send_frame(f, 0); model_push(f);
        idle(3);
        f = '{default: 4'd0}; f[8] = 4'd1; f[9] = 4'd2;
        send_frame(f, 0); model_push(f);
        wait_caps(exp_q.size());
        idle(12);
        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL directed_count got %0d want %0d", cap_q.size(), exp_q.size());
        end
        if (cap_q.size() > 0) begin
            n_checks++;
            if (cap_q[0].cyc != first_last + 2) begin
                n_errors++;
                $display("FAIL first_latency got cycle %0d want %0d", cap_q[0].cyc, first_last + 2);
            end
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if ({cap_q[i].y, cap_q[i].sof, cap_q[i].corr, cap_q[i].fail} !==
                {exp_q[i].y, exp_q[i].sof, exp_q[i].corr, exp_q[i].fail}) begin
                n_errors++;
                $display("FAIL directed_sym%0d got y=%h sof=%b corr=%b fail=%b want y=%h sof=%b corr=%b fail=%b",
                         i, cap_q[i].y, cap_q[i].sof, cap_q[i].corr, cap_q[i].fail,
                         exp_q[i].y, exp_q[i].sof, exp_q[i].corr, exp_q[i].fail);
            end
            if (i % 10 == 9) $display("tb: directed frame %0d checked", i / 10);
        end
    endtask

    task automatic test_random();
        frame_t f;
        cap_q.delete(); exp_q.delete();
        idle_bad = 0;
        for (int n = 0; n < 40; n++) begin
            make_codeword(f);
            add_errors(f, $urandom_range(0, 2));
            send_frame(f, $urandom_range(0, 1));
            model_push(f);
            idle($urandom_range(0, 3));
        end
        wait_caps(exp_q.size());
        idle(12);
        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL random_count got %0d want %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if ({cap_q[i].y, cap_q[i].sof, cap_q[i].corr, cap_q[i].fail} !==
                {exp_q[i].y, exp_q[i].sof, exp_q[i].corr, exp_q[i].fail}) begin
                n_errors++;
                $display("FAIL random_sym%0d got y=%h sof=%b corr=%b fail=%b want y=%h sof=%b corr=%b fail=%b",
                         i, cap_q[i].y, cap_q[i].sof, cap_q[i].corr, cap_q[i].fail,
                         exp_q[i].y, exp_q[i].sof, exp_q[i].corr, exp_q[i].fail);
            end
            if (i % 10 == 9) $display("tb: random frame %0d checked", i / 10);
        end
        n_checks++;
        if (idle_bad != 0) begin
            n_errors++;
            $display("FAIL idle_outputs got %0d nonzero idle cycles want 0", idle_bad);
        end
    endtask

    task automatic test_back_to_back();
        frame_t f;
        cap_q.delete(); exp_q.delete();
        for (int n = 0; n < 3; n++) begin
            make_codeword(f);
            add_errors(f, n % 2);
            send_frame(f, 0);
            model_push(f);
        end
        wait_caps(30);
        idle(12);
        n_checks++;
        if (cap_q.size() != 30) begin
            n_errors++;
            $display("FAIL b2b_count got %0d want 30", cap_q.size());
        end else begin
            n_checks++;
            if (cap_q[29].cyc - cap_q[0].cyc != 29) begin
                n_errors++;
                $display("FAIL b2b_contiguous got span %0d want 29", cap_q[29].cyc - cap_q[0].cyc);
            end
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if ({cap_q[i].y, cap_q[i].sof, cap_q[i].corr, cap_q[i].fail} !==
                {exp_q[i].y, exp_q[i].sof, exp_q[i].corr, exp_q[i].fail}) begin
                n_errors++;
                $display("FAIL b2b_sym%0d got y=%h sof=%b corr=%b fail=%b want y=%h sof=%b corr=%b fail=%b",
                         i, cap_q[i].y, cap_q[i].sof, cap_q[i].corr, cap_q[i].fail,
                         exp_q[i].y, exp_q[i].sof, exp_q[i].corr, exp_q[i].fail);
            end
        end
        $display("tb: back-to-back burst checked");

        cap_q.delete(); exp_q.delete();
        make_codeword(f);
        add_errors(f, 1);
        send_frame(f, 2);
        model_push(f);
        wait_caps(10);
        idle(12);
        n_checks++;
        if (cap_q.size() != 10) begin
            n_errors++;
            $display("FAIL gap_count got %0d want 10", cap_q.size());
        end else begin
            n_checks++;
            if (cap_q[9].cyc - cap_q[0].cyc != 9) begin
                n_errors++;
                $display("FAIL gap_burst got span %0d want 9", cap_q[9].cyc - cap_q[0].cyc);
            end
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if ({cap_q[i].y, cap_q[i].sof, cap_q[i].corr, cap_q[i].fail} !==
                {exp_q[i].y, exp_q[i].sof, exp_q[i].corr, exp_q[i].fail}) begin
                n_errors++;
                $display("FAIL gap_sym%0d got y=%h sof=%b corr=%b fail=%b want y=%h sof=%b corr=%b fail=%b",
                         i, cap_q[i].y, cap_q[i].sof, cap_q[i].corr, cap_q[i].fail,
                         exp_q[i].y, exp_q[i].sof, exp_q[i].corr, exp_q[i].fail);
            end
        end
        $display("tb: gapped frame checked");
    endtask

    task automatic test_resync();
        frame_t f, p;
        cap_q.delete(); exp_q.delete();
        make_codeword(p);
        for (int i = 0; i < 5; i++) send_sym(1'b1, (i == 0), p[i]);
        make_codeword(f);
        add_errors(f, 1);
        send_frame(f, 0);
        model_push(f);
        wait_caps(10);
        idle(15);
        n_checks++;
        if (cap_q.size() != 10) begin
            n_errors++;
            $display("FAIL resync_count got %0d want 10", cap_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if ({cap_q[i].y, cap_q[i].sof, cap_q[i].corr, cap_q[i].fail} !==
                {exp_q[i].y, exp_q[i].sof, exp_q[i].corr, exp_q[i].fail}) begin
                n_errors++;
                $display("FAIL resync_sym%0d got y=%h sof=%b corr=%b fail=%b want y=%h sof=%b corr=%b fail=%b",
                         i, cap_q[i].y, cap_q[i].sof, cap_q[i].corr, cap_q[i].fail,
                         exp_q[i].y, exp_q[i].sof, exp_q[i].corr, exp_q[i].fail);
            end
        end
        $display("tb: resync frame checked");
    endtask

    task automatic test_reset_mid_play();
        frame_t a, b, c;
        cap_q.delete(); exp_q.delete();
        make_codeword(a);
        make_codeword(b);
        send_frame(a, 0);
        for (int i = 0; i < 5; i++) send_sym(1'b1, (i == 0), b[i]);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus_if.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midplay_valid got %b want 0", bus_if.out_valid);
        end
        n_checks++;
        if ({bus_if.y, bus_if.out_sof, bus_if.out_corr, bus_if.out_fail} !== 7'd0) begin
            n_errors++;
            $display("FAIL midplay_outputs got %h want 0",
                     {bus_if.y, bus_if.out_sof, bus_if.out_corr, bus_if.out_fail});
        end
        idle(3);
        reset = 1'b1;
        cap_q.delete();
        for (int i = 5; i < 10; i++) send_sym(1'b1, 1'b0, b[i]);
        for (int i = 0; i < 12; i++) send_sym(1'b1, 1'b0, 4'($urandom_range(0, 15)));
        idle(15);
        n_checks++;
        if (cap_q.size() != 0) begin
            n_errors++;
            $display("FAIL post_reset_quiet got %0d outputs want 0", cap_q.size());
        end
        cap_q.delete();
        make_codeword(c);
        add_errors(c, 1);
        send_frame(c, 0);
        model_push(c);
        wait_caps(10);
        idle(12);
        n_checks++;
        if (cap_q.size() != 10) begin
            n_errors++;
            $display("FAIL post_reset_count got %0d want 10", cap_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if ({cap_q[i].y, cap_q[i].sof, cap_q[i].corr, cap_q[i].fail} !==
                {exp_q[i].y, exp_q[i].sof, exp_q[i].corr, exp_q[i].fail}) begin
                n_errors++;
                $display("FAIL post_reset_sym%0d got y=%h sof=%b corr=%b fail=%b want y=%h sof=%b corr=%b fail=%b",
                         i, cap_q[i].y, cap_q[i].sof, cap_q[i].corr, cap_q[i].fail,
                         exp_q[i].y, exp_q[i].sof, exp_q[i].corr, exp_q[i].fail);
            end
        end
        $display("tb: reset during playback checked");
    endtask

    initial begin
        bus_if.in_valid = 1'b0;
        bus_if.in_sof   = 1'b0;
        bus_if.x        = 4'd0;
        build_tables();
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_resync();
        test_reset_mid_play();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
